// File: rtl/ysyx_23060187_lsu_if.sv
// Handshake bundles around the load/store unit.
//   ysyx_23060187_lsu_req_if : execute stage (master) <-> LSU (slave), request and response
//   ysyx_23060187_lsu_mem_if : LSU (master) <-> data memory (slave)
interface ysyx_23060187_lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        lbu;
  logic        lh;
  logic        lhu;
  logic        lw;
  logic        sb;
  logic        sh;
  logic        sw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;

  modport master (
    output req_valid, lbu, lh, lhu, lw, sb, sh, sw, addr, wdata, rd, resp_ready,
    input  req_ready, resp_valid, rdata, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, lbu, lh, lhu, lw, sb, sh, sw, addr, wdata, rd, resp_ready,
    output req_ready, resp_valid, rdata, resp_rd, resp_err
  );
endinterface

interface ysyx_23060187_lsu_mem_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060187_lsu.sv
// Load/store unit: accepts one decoded memory op at a time, checks alignment,
// issues a single word-aligned memory request, extends load data and returns
// a response. All outputs come straight from registers.
module ysyx_23060187_lsu (
  input  logic                           clk,
  input  logic                           rst_n,
  ysyx_23060187_lsu_req_if.slave         req_if,
  ysyx_23060187_lsu_mem_if.master        mem_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic [4:0]  r_resp_rd;
  logic        r_resp_err;
  logic        r_mem_valid;
  logic        r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wmask;

  // Load flavour and byte lane captured at accept; they steer extraction in WAIT.
  logic        r_lbu;
  logic        r_lh;
  logic        r_lhu;
  logic        r_lw;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;

  logic [6:0]  w_flags;
  logic        w_bad_flags;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_is_store;
  logic [3:0]  w_acc_wmask;
  logic [31:0] w_acc_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Accept-time decode: legality check plus store lane mask and replicated data.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_acc_wmask  = 4'b0000;
    w_acc_wdata  = 32'h0000_0000;
    w_flags      = {req_if.lbu, req_if.lh, req_if.lhu, req_if.lw,
                    req_if.sb, req_if.sh, req_if.sw};
    // Zero flags, or more than one flag set, is not a valid decode.
    w_bad_flags  = (w_flags == 7'd0) || ((w_flags & (w_flags - 7'd1)) != 7'd0);
    w_misaligned = ((req_if.lh | req_if.lhu | req_if.sh) & req_if.addr[0]) |
                   ((req_if.lw | req_if.sw) & (req_if.addr[1:0] != 2'b00));
    w_illegal    = w_bad_flags | w_misaligned;
    w_is_store   = req_if.sb | req_if.sh | req_if.sw;
    if (req_if.sb) begin
      w_acc_wmask = 4'b0001 << req_if.addr[1:0];
      w_acc_wdata = {4{req_if.wdata[7:0]}};
    end else if (req_if.sh) begin
      w_acc_wmask = 4'b0011 << req_if.addr[1:0];
      w_acc_wdata = {2{req_if.wdata[15:0]}};
    end else if (req_if.sw) begin
      w_acc_wmask = 4'b1111;
      w_acc_wdata = req_if.wdata;
    end
  end

  // Load extraction from the returned word using the latched lane and op.
  always_comb begin
    w_load_data = 32'h0000_0000;
    case (r_lane)
      2'd0:    w_byte = mem_if.mem_rdata[7:0];
      2'd1:    w_byte = mem_if.mem_rdata[15:8];
      2'd2:    w_byte = mem_if.mem_rdata[23:16];
      default: w_byte = mem_if.mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_if.mem_rdata[31:16] : mem_if.mem_rdata[15:0];
    if (r_lbu) begin
      w_load_data = {24'h00_0000, w_byte};
    end else if (r_lh) begin
      w_load_data = {{16{w_half[15]}}, w_half};
    end else if (r_lhu) begin
      w_load_data = {16'h0000, w_half};
    end else if (r_lw) begin
      w_load_data = mem_if.mem_rdata;
    end
  end

  // Transaction FSM with all outputs registered; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0000_0000;
      r_resp_rd    <= 5'd0;
      r_resp_err   <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_mem_wmask  <= 4'b0000;
      r_lbu        <= 1'b0;
      r_lh         <= 1'b0;
      r_lhu        <= 1'b0;
      r_lw         <= 1'b0;
      r_lane       <= 2'd0;
      r_rd         <= 5'd0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (req_if.req_valid) begin
            r_req_ready <= 1'b0;
            r_lbu       <= req_if.lbu;
            r_lh        <= req_if.lh;
            r_lhu       <= req_if.lhu;
            r_lw        <= req_if.lw;
            r_lane      <= req_if.addr[1:0];
            r_rd        <= req_if.rd;
            if (w_illegal) begin
              // Rejected without touching memory.
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_rdata      <= 32'h0000_0000;
              r_resp_rd    <= req_if.rd;
            end else begin
              r_state     <= S_REQ;
              r_mem_valid <= 1'b1;
              r_mem_wen   <= w_is_store;
              r_mem_addr  <= {req_if.addr[31:2], 2'b00};
              r_mem_wdata <= w_acc_wdata;
              r_mem_wmask <= w_acc_wmask;
            end
          end
        end
        S_REQ: begin
          if (mem_if.mem_ready) begin
            r_mem_valid <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_wmask <= 4'b0000;
            if (r_mem_wen) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_rdata      <= 32'h0000_0000;
              r_resp_rd    <= r_rd;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_if.mem_rvalid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_rdata      <= w_load_data;
            r_resp_rd    <= r_rd;
          end
        end
        S_RESP: begin
          if (req_if.resp_ready) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'h0000_0000;
            r_resp_rd    <= 5'd0;
            r_resp_err   <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_if.req_ready  = r_req_ready;
  assign req_if.resp_valid = r_resp_valid;
  assign req_if.rdata      = r_rdata;
  assign req_if.resp_rd    = r_resp_rd;
  assign req_if.resp_err   = r_resp_err;
  assign mem_if.mem_valid  = r_mem_valid;
  assign mem_if.mem_wen    = r_mem_wen;
  assign mem_if.mem_addr   = r_mem_addr;
  assign mem_if.mem_wdata  = r_mem_wdata;
  assign mem_if.mem_wmask  = r_mem_wmask;

endmodule

// File: tb/tb_ysyx_23060187_lsu.sv
// Self-checking bench for ysyx_23060187_lsu: directed scenarios plus randomized
// traffic compared against an arithmetic reference model of the LSU rules.
`timescale 1ns/1ps
module tb_ysyx_23060187_lsu;

  typedef enum int {OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_NONE, OP_MULTI} op_e;

  typedef struct {
    logic        illegal;
    logic        store;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwmask;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        accept_ready;
    logic        mem_seen;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_unstable;
    logic        mem_extra;
    logic        ready_leak;
    logic        resp_unstable;
    logic        timeout;
    int          resp_lat;
    logic [31:0] rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        post_ready;
    logic        post_valid;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ysyx_23060187_lsu_req_if req_if ();
  ysyx_23060187_lsu_mem_if mem_if ();

  ysyx_23060187_lsu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_if (req_if.slave),
    .mem_if (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: expected request/response derived from the op rules.
  function automatic exp_t model(op_e op, logic [31:0] addr, logic [31:0] wd, logic [31:0] rword);
    exp_t        e;
    int unsigned lane;
    int unsigned b;
    int unsigned h;
    e = '{default: 0};
    lane = addr % 4;
    e.maddr = addr - lane;
    e.illegal = (op == OP_NONE) || (op == OP_MULTI) ||
                ((op == OP_LH || op == OP_LHU || op == OP_SH) && (addr % 2 == 1)) ||
                ((op == OP_LW || op == OP_SW) && lane != 0);
    if (e.illegal) return e;
    b = (rword >> (8 * lane)) & 32'hFF;
    h = (rword >> (16 * (lane / 2))) & 32'hFFFF;
    case (op)
      OP_LBU: e.rdata = b;
      OP_LH:  e.rdata = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      OP_LHU: e.rdata = h;
      OP_LW:  e.rdata = rword;
      OP_SB: begin e.store = 1; e.mwmask = 4'(1 << lane); e.mwdata = (wd & 32'hFF) * 32'h0101_0101; end
      OP_SH: begin e.store = 1; e.mwmask = 4'(3 << lane); e.mwdata = (wd & 32'hFFFF) * 32'h0001_0001; end
      OP_SW: begin e.store = 1; e.mwmask = 4'hF; e.mwdata = wd; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic int exp_latency(op_e op, exp_t e, int mem_stall, int rv_stall);
    if (e.illegal) return 1;
    if (op == OP_SB || op == OP_SH || op == OP_SW) return 2 + mem_stall;
    return 3 + mem_stall + rv_stall;
  endfunction

  task automatic set_flag(int idx);
    case (idx)
      0: req_if.lbu = 1'b1;
      1: req_if.lh  = 1'b1;
      2: req_if.lhu = 1'b1;
      3: req_if.lw  = 1'b1;
      4: req_if.sb  = 1'b1;
      5: req_if.sh  = 1'b1;
      default: req_if.sw = 1'b1;
    endcase
  endtask

  task automatic drive_req(op_e op, logic [31:0] addr, logic [31:0] wd, logic [4:0] rd);
    int i;
    req_if.req_valid = 1'b1;
    {req_if.lbu, req_if.lh, req_if.lhu, req_if.lw, req_if.sb, req_if.sh, req_if.sw} = 7'd0;
    if (op == OP_MULTI) begin
      i = $urandom_range(0, 6);
      set_flag(i);
      set_flag((i + $urandom_range(1, 6)) % 7);
    end else if (op != OP_NONE) begin
      set_flag(int'(op));
    end
    req_if.addr  = addr;
    req_if.wdata = wd;
    req_if.rd    = rd;
  endtask

  // Garbage on the request side while busy; the LSU must ignore it.
  task automatic scramble_req();
    req_if.req_valid = 1'($urandom_range(0, 1));
    {req_if.lbu, req_if.lh, req_if.lhu, req_if.lw, req_if.sb, req_if.sh, req_if.sw} = 7'($urandom);
    req_if.addr  = $urandom;
    req_if.wdata = $urandom;
    req_if.rd    = 5'($urandom);
  endtask

  // Plays execute stage and memory for one transaction and records what it saw.
  // Starts and ends on a falling edge with the LSU expected idle.
  task automatic run_txn(input op_e op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rword, input int mem_stall,
                         input int rv_stall, input int resp_stall, output obs_t o);
    int   cyc;
    int   stall_cnt;
    int   rv_cnt;
    logic mem_hs;
    logic rv_real;
    logic rv_done;
    logic done;
    logic is_load;
    o = '{default: 0};
    o.resp_lat = -1;
    cyc = 0; stall_cnt = 0; rv_cnt = 0;
    mem_hs = 0; rv_real = 0; rv_done = 0; done = 0;
    is_load = (op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW);
    o.accept_ready = req_if.req_ready;
    drive_req(op, addr, wd, rd);
    mem_if.mem_ready = 0; mem_if.mem_rvalid = 0; req_if.resp_ready = 0;
    while (!done) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cyc == 1) scramble_req();
      if (rv_real) begin rv_real = 0; rv_done = 1; end
      mem_if.mem_rvalid = 0;
      mem_if.mem_rdata  = $urandom;
      if (mem_if.mem_ready) begin mem_if.mem_ready = 0; mem_hs = 1; end
      if (req_if.req_ready) o.ready_leak = 1;
      if (req_if.resp_valid) begin
        o.resp_lat = cyc;
        o.rdata    = req_if.rdata;
        o.resp_rd  = req_if.resp_rd;
        o.resp_err = req_if.resp_err;
        if (mem_if.mem_valid) o.mem_extra = 1;
        req_if.resp_ready = 0;
        for (int k = 0; k < resp_stall; k++) begin
          @(posedge clk); @(negedge clk);
          if (req_if.resp_valid !== 1'b1 || req_if.rdata !== o.rdata || req_if.resp_rd !== o.resp_rd ||
              req_if.resp_err !== o.resp_err || req_if.req_ready !== 1'b0 || mem_if.mem_valid !== 1'b0)
            o.resp_unstable = 1;
        end
        req_if.resp_ready = 1;
        @(posedge clk); @(negedge clk);
        req_if.resp_ready = 0;
        req_if.req_valid  = 0;
        o.post_ready = req_if.req_ready;
        o.post_valid = req_if.resp_valid;
        done = 1;
      end else if (cyc > 300) begin
        o.timeout = 1;
        done = 1;
      end else begin
        req_if.resp_ready = 1'($urandom_range(0, 1));
        if (mem_if.mem_valid) begin
          if (mem_hs) o.mem_extra = 1;
          if (!o.mem_seen) begin
            o.mem_seen  = 1;
            o.mem_wen   = mem_if.mem_wen;
            o.mem_addr  = mem_if.mem_addr;
            o.mem_wdata = mem_if.mem_wdata;
            o.mem_wmask = mem_if.mem_wmask;
          end else if ({mem_if.mem_wen, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask} !==
                       {o.mem_wen, o.mem_addr, o.mem_wdata, o.mem_wmask}) begin
            o.mem_unstable = 1;
          end
          if (stall_cnt >= mem_stall) mem_if.mem_ready = 1;
          else begin stall_cnt++; mem_if.mem_rvalid = 1'($urandom_range(0, 1)); end
        end
        if (mem_hs && is_load && !rv_done) begin
          if (rv_cnt >= rv_stall) begin
            mem_if.mem_rvalid = 1; mem_if.mem_rdata = rword; rv_real = 1;
          end else rv_cnt++;
        end
      end
    end
    req_if.req_valid = 0; req_if.resp_ready = 0;
    mem_if.mem_ready = 0; mem_if.mem_rvalid = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_if.req_valid = 0; req_if.resp_ready = 0;
    {req_if.lbu, req_if.lh, req_if.lhu, req_if.lw, req_if.sb, req_if.sh, req_if.sw} = 7'd0;
    req_if.addr = 0; req_if.wdata = 0; req_if.rd = 0;
    mem_if.mem_ready = 0; mem_if.mem_rvalid = 0; mem_if.mem_rdata = 0;
    repeat (3) @(negedge clk);
    n_tests++; if (req_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_if.req_ready); end
    n_tests++;
    if ({req_if.resp_valid, mem_if.mem_valid, mem_if.mem_wen, mem_if.mem_wmask, mem_if.mem_addr, mem_if.mem_wdata,
         req_if.rdata, req_if.resp_rd, req_if.resp_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs resp_valid=%b mem_valid=%b wen=%b wmask=%h addr=%h wdata=%h rdata=%h rd=%0d err=%b exp all zero",
        req_if.resp_valid, mem_if.mem_valid, mem_if.mem_wen, mem_if.mem_wmask, mem_if.mem_addr, mem_if.mem_wdata,
        req_if.rdata, req_if.resp_rd, req_if.resp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads();
    obs_t o;
    run_txn(OP_LW, 32'h8000_0004, 32'h0, 5'd10, 32'hDEAD_BEEF, 0, 0, 0, o);
    n_tests++; if (o.mem_addr !== 32'h8000_0004 || o.mem_wmask !== 4'b0000 || o.mem_wen !== 1'b0)
      begin n_fail++; $display("FAIL lw_mem got addr=%h wmask=%b wen=%b exp 80000004/0000/0", o.mem_addr, o.mem_wmask, o.mem_wen); end
    n_tests++; if (o.rdata !== 32'hDEAD_BEEF || o.resp_err !== 1'b0 || o.resp_rd !== 5'd10)
      begin n_fail++; $display("FAIL lw_resp got rdata=%h err=%b rd=%0d exp deadbeef/0/10", o.rdata, o.resp_err, o.resp_rd); end
    n_tests++; if (o.resp_lat !== 3) begin n_fail++; $display("FAIL lw_latency got=%0d exp=3", o.resp_lat); end
    run_txn(OP_LH, 32'h8000_0002, 32'h0, 5'd3, 32'h8001_1234, 0, 0, 0, o);
    n_tests++; if (o.rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_rdata got=%h exp=ffff8001", o.rdata); end
    run_txn(OP_LHU, 32'h8000_0002, 32'h0, 5'd4, 32'h8001_1234, 0, 0, 0, o);
    n_tests++; if (o.rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_rdata got=%h exp=00008001", o.rdata); end
    run_txn(OP_LBU, 32'h8000_0003, 32'h0, 5'd5, 32'h8001_1234, 0, 0, 0, o);
    n_tests++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata got=%h exp=00000080", o.rdata); end
  endtask

  task automatic test_store();
    obs_t o;
    run_txn(OP_SB, 32'h8000_0003, 32'h0000_00AB, 5'd9, 32'h0, 0, 0, 0, o);
    n_tests++; if (o.mem_wen !== 1'b1 || o.mem_wmask !== 4'b1000 || o.mem_wdata !== 32'hABAB_ABAB || o.mem_addr !== 32'h8000_0000)
      begin n_fail++; $display("FAIL sb_mem got wen=%b wmask=%b wdata=%h addr=%h exp 1/1000/abababab/80000000",
        o.mem_wen, o.mem_wmask, o.mem_wdata, o.mem_addr); end
    n_tests++; if (o.resp_lat !== 2 || o.rdata !== 32'h0 || o.resp_err !== 1'b0 || o.resp_rd !== 5'd9)
      begin n_fail++; $display("FAIL sb_resp got lat=%0d rdata=%h err=%b rd=%0d exp 2/0/0/9", o.resp_lat, o.rdata, o.resp_err, o.resp_rd); end
  endtask

  task automatic test_illegal();
    obs_t o;
    op_e  ops[4]   = '{OP_SW, OP_LH, OP_NONE, OP_MULTI};
    logic [31:0] adr[4] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      run_txn(ops[i], adr[i], 32'h1234_5678, 5'd1, 32'h0, 0, 0, 0, o);
      n_tests++; if (o.mem_seen !== 1'b0 || o.resp_lat !== 1 || o.resp_err !== 1'b1 || o.rdata !== 32'h0)
        begin n_fail++; $display("FAIL illegal_%0d got mem_seen=%b lat=%0d err=%b rdata=%h exp 0/1/1/0",
          i, o.mem_seen, o.resp_lat, o.resp_err, o.rdata); end
    end
  endtask

  task automatic test_backpressure();
    obs_t        o;
    logic [31:0] w;
    w = $urandom;
    run_txn(OP_LW, 32'h8000_0008, 32'h0, 5'd12, w, 5, 2, 3, o);
    n_tests++; if ({o.mem_unstable, o.resp_unstable, o.ready_leak, o.mem_extra, o.timeout} !== 5'b0)
      begin n_fail++; $display("FAIL bp_load_stability got unstable_mem=%b unstable_resp=%b ready_leak=%b extra=%b timeout=%b exp all 0",
        o.mem_unstable, o.resp_unstable, o.ready_leak, o.mem_extra, o.timeout); end
    n_tests++; if (o.resp_lat !== 10 || o.rdata !== w || o.post_ready !== 1'b1 || o.post_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_load_resp got lat=%0d rdata=%h post_ready=%b post_valid=%b exp 10/%h/1/0",
        o.resp_lat, o.rdata, o.post_ready, o.post_valid, w); end
    run_txn(OP_SH, 32'h8000_0006, 32'hCAFE_1357, 5'd13, 32'h0, 5, 0, 3, o);
    n_tests++; if ({o.mem_unstable, o.resp_unstable, o.ready_leak} !== 3'b0 || o.mem_wmask !== 4'b1100 ||
                   o.mem_wdata !== 32'h1357_1357 || o.resp_lat !== 7)
      begin n_fail++; $display("FAIL bp_store got unstable=%b%b leak=%b wmask=%b wdata=%h lat=%0d exp 00/0/1100/13571357/7",
        o.mem_unstable, o.resp_unstable, o.ready_leak, o.mem_wmask, o.mem_wdata, o.resp_lat); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic bad_resp;
    logic bad_ready;
    drive_req(OP_LW, 32'h8000_0010, 32'h0, 5'd7);
    @(posedge clk); @(negedge clk);
    req_if.req_valid = 0;
    n_tests++; if (mem_if.mem_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_mem_valid got=%b exp=1", mem_if.mem_valid); end
    mem_if.mem_ready = 1;
    @(posedge clk); @(negedge clk);
    mem_if.mem_ready = 0;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (req_if.req_ready !== 1'b1 || {req_if.resp_valid, mem_if.mem_valid, mem_if.mem_wen, mem_if.mem_wmask, mem_if.mem_addr,
        mem_if.mem_wdata, req_if.rdata, req_if.resp_rd, req_if.resp_err} !== '0) begin
      n_fail++; $display("FAIL rstmid_async got req_ready=%b resp_valid=%b mem_valid=%b addr=%h exp 1/0/0/0",
        req_if.req_ready, req_if.resp_valid, mem_if.mem_valid, mem_if.mem_addr);
    end
    mem_if.mem_rvalid = 1; mem_if.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst_n = 1'b1;
    bad_resp = 0; bad_ready = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (req_if.resp_valid !== 1'b0 || mem_if.mem_valid !== 1'b0) bad_resp = 1;
      if (req_if.req_ready !== 1'b1) bad_ready = 1;
    end
    mem_if.mem_rvalid = 0;
    n_tests++; if (bad_resp !== 1'b0 || bad_ready !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_stray_rvalid got spurious_activity=%b ready_drop=%b exp 0/0", bad_resp, bad_ready); end
    run_txn(OP_LW, 32'h8000_0020, 32'h0, 5'd8, 32'h0BAD_F00D, 0, 0, 0, o);
    n_tests++; if (o.rdata !== 32'h0BAD_F00D || o.resp_lat !== 3 || o.resp_err !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_next_lw got rdata=%h lat=%0d err=%b exp 0badf00d/3/0", o.rdata, o.resp_lat, o.resp_err); end
  endtask

  // Randomized traffic; back_to_back issues with zero stalls so each request
  // follows the previous response immediately.
  task automatic run_random(string tag, int count, int max_stall);
    obs_t        o;
    exp_t        e;
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rword;
    logic [4:0]  rd;
    int          ms;
    int          rs;
    int          ps;
    int          lat;
    for (int i = 0; i < count; i++) begin
      op    = op_e'($urandom_range(0, 8));
      addr  = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd    = $urandom;
      rword = $urandom;
      rd    = 5'($urandom);
      ms    = $urandom_range(0, max_stall);
      rs    = $urandom_range(0, max_stall);
      ps    = $urandom_range(0, max_stall);
      e     = model(op, addr, wd, rword);
      lat   = exp_latency(op, e, ms, rs);
      run_txn(op, addr, wd, rd, rword, ms, rs, ps, o);
      n_tests++; if (o.resp_lat !== lat || o.resp_err !== e.illegal || o.rdata !== e.rdata)
        begin n_fail++; $display("FAIL %s_%0d_resp op=%0d addr=%h got lat=%0d err=%b rdata=%h exp %0d/%b/%h",
          tag, i, int'(op), addr, o.resp_lat, o.resp_err, o.rdata, lat, e.illegal, e.rdata); end
      n_tests++; if ({o.timeout, o.mem_unstable, o.mem_extra, o.ready_leak, o.resp_unstable, o.post_valid,
                      ~o.post_ready, ~o.accept_ready} !== 8'b0)
        begin n_fail++; $display("FAIL %s_%0d_protocol got to=%b mu=%b mx=%b rl=%b ru=%b pv=%b pr=%b ar=%b exp 0/0/0/0/0/0/1/1",
          tag, i, o.timeout, o.mem_unstable, o.mem_extra, o.ready_leak, o.resp_unstable, o.post_valid, o.post_ready, o.accept_ready); end
      if (e.illegal) begin
        n_tests++; if (o.mem_seen !== 1'b0) begin n_fail++; $display("FAIL %s_%0d_no_mem got mem_seen=%b exp=0", tag, i, o.mem_seen); end
      end else begin
        n_tests++; if (o.mem_seen !== 1'b1 || o.mem_wen !== e.store || o.mem_addr !== e.maddr ||
                       o.mem_wmask !== e.mwmask || o.resp_rd !== rd)
          begin n_fail++; $display("FAIL %s_%0d_mem op=%0d got seen=%b wen=%b addr=%h wmask=%b rd=%0d exp 1/%b/%h/%b/%0d",
            tag, i, int'(op), o.mem_seen, o.mem_wen, o.mem_addr, o.mem_wmask, o.resp_rd, e.store, e.maddr, e.mwmask, rd); end
        if (e.store) begin
          n_tests++; if (o.mem_wdata !== e.mwdata)
            begin n_fail++; $display("FAIL %s_%0d_wdata got=%h exp=%h", tag, i, o.mem_wdata, e.mwdata); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_random("b2b", 12, 0);
  endtask

  task automatic test_random();
    run_random("rand", 60, 3);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_loads();
    test_store();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060187_lsu.md
YSYX_23060187_LSU -- requirements
Module: ysyx_23060187_lsu

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 req_valid  in  1  execute stage presents a memory op.
REQ-004 req_ready  out  1  LSU can accept a request.
REQ-005 lbu, lh, lhu, lw, sb, sh, sw  in  1 each  decoded op flags, one-hot, qualified by req_valid.
REQ-006 addr  in  32  effective byte address; wdata  in  32  store data (low bits used for sb/sh); rd  in  5  destination register.
REQ-007 resp_valid  out  1; resp_ready  in  1  completion handshake toward writeback.
REQ-008 rdata  out  32  extended load result; resp_rd  out  5; resp_err  out  1  misaligned or illegal op.
REQ-009 mem_valid  out  1; mem_ready  in  1  memory request handshake.
REQ-010 mem_wen  out  1; mem_addr  out  32, word-aligned (addr[1:0] forced 0); mem_wdata  out  32; mem_wmask  out  4.
REQ-011 mem_rvalid  in  1; mem_rdata  in  32  aligned read word.

Function
REQ-012 FSM states IDLE, REQ, WAIT, RESP; one state per cycle; no other states.
REQ-013 IDLE: req_ready=1; all other outputs idle. On req_valid: latch flags, addr, wdata, rd.
REQ-014 Accept-time check: lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=0, zero flags, or more than one flag -> illegal; go to RESP with resp_err=1, rdata=0; no memory access.
REQ-015 Legal accept -> REQ.
REQ-016 REQ: mem_valid=1; mem_wen=1 for sb/sh/sw; mem_addr/mem_wdata/mem_wmask held stable until mem_ready.
REQ-017 REQ and mem_ready: store -> RESP; load -> WAIT.
REQ-018 WAIT: sample mem_rvalid only here. On mem_rvalid: capture and extend mem_rdata into rdata register; go to RESP. Wait indefinitely otherwise.
REQ-019 RESP: resp_valid=1; rdata, resp_rd, resp_err stable; on resp_ready -> IDLE. No new request is accepted in the same cycle (req_ready=0 outside IDLE).
REQ-020 Store mask: sb -> 4'b0001<<addr[1:0]; sh -> 4'b0011<<addr[1:0]; sw -> 4'b1111. mem_wdata = byte/half replicated across all lanes (sb: {4{wdata[7:0]}}, sh: {2{wdata[15:0]}}, sw: wdata).
REQ-021 Load extraction: lane = addr[1:0]; lbu zero-extends byte at lane; lh sign-extends half at addr[1]; lhu zero-extends it; lw passes the word unchanged.
REQ-022 Store response: rdata=0, resp_err=0, resp_rd = latched rd (writeback ignores it for stores).
REQ-023 Minimum latency, accept edge = cycle 0: store resp_valid in cycle 2; load resp_valid in cycle 3 (mem_ready in cycle 1, mem_rvalid in cycle 2).
REQ-024 Inputs in states other than IDLE are ignored; latched values alone drive outputs.

Reset
REQ-025 rst_n=0 forces IDLE immediately (asynchronously): req_ready=1, resp_valid=0, mem_valid=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0, rdata=0, resp_rd=0, resp_err=0.
REQ-026 Reset mid-transaction abandons it; no response is produced; a later mem_rvalid in IDLE is ignored.

Verification
REQ-027 lw addr=0x80000004, mem_ready in cycle 1, mem_rvalid in cycle 2 with mem_rdata=0xDEADBEEF -> mem_addr=0x80000004, mem_wmask=0; rdata=0xDEADBEEF, resp_err=0, resp_valid in cycle 3.
REQ-028 lh addr=0x80000002, mem_rdata=0x8001_1234 -> rdata=0xFFFF8001; same with lhu -> 0x00008001; lbu addr=...3 -> 0x00000080.
REQ-029 sb addr=0x80000003, wdata=0x000000AB -> mem_wen=1, mem_wmask=4'b1000, mem_wdata=0xABABABAB, mem_addr=0x80000000, resp_valid in cycle 2.
REQ-030 sw addr=0x80000002 -> no mem_valid ever; resp_valid in cycle 1 with resp_err=1, rdata=0; lh addr=...1 behaves the same way.
REQ-031 Backpressure: mem_ready held low 5 cycles, resp_ready held low 3 cycles -> mem_* outputs and resp_* outputs stable throughout, req_ready=0 until the resp handshake.
REQ-032 rst_n pulsed low while in WAIT, followed by mem_rvalid=1 -> outputs at reset values within the same cycle; no resp_valid; next lw completes normally.
